// File: rtl/mdu_op_unit.sv
// RV32M/RV64M multiply/divide unit: decodes funct7/funct3, then runs a
// radix-2 shift-add multiply or a restoring divide, one bit per cycle.
module mdu_op_unit #(
  parameter int unsigned XLEN    = 32,
  parameter bit          HAS_DIV = 1'b1
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            error
);

  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [6:0]      F7_MULDIV = 7'b0000001;
  localparam logic [2:0]      F3_MUL    = 3'd0;
  localparam logic [2:0]      F3_MULH   = 3'd1;
  localparam logic [2:0]      F3_MULHSU = 3'd2;
  localparam logic [2:0]      F3_DIV    = 3'd4;
  localparam logic [2:0]      F3_REM    = 3'd6;
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Datapath registers: acc holds {hi, multiplier} for MUL, {rem, dividend/quotient} for DIV.
  logic [W2-1:0]   acc_q;
  logic [XLEN-1:0] mcand_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic            rneg_q;
  logic [XLEN-1:0] res_q;
  logic            err_q;

  logic            in_ready_d;
  logic            out_valid_d;
  logic            error_d;
  logic [XLEN-1:0] result_d;

  // Accept-time decode, taken straight from the request inputs.
  logic            accept_c;
  logic            is_div_c;
  logic            illegal_c;
  logic            a_signed_c;
  logic            b_signed_c;
  logic            a_neg_c;
  logic            b_neg_c;
  logic [XLEN-1:0] a_mag_c;
  logic [XLEN-1:0] b_mag_c;
  logic            div_zero_c;
  logic            div_ovf_c;
  logic            fast_c;
  logic [XLEN-1:0] fast_res_c;

  always_comb begin
    accept_c   = (state_q == S_IDLE) && in_valid && !flush;
    is_div_c   = funct3[2];
    illegal_c  = (funct7 != F7_MULDIV) || (is_div_c && !HAS_DIV);
    a_signed_c = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                 (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed_c = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg_c    = a_signed_c && op_a[XLEN-1];
    b_neg_c    = b_signed_c && op_b[XLEN-1];
    a_mag_c    = a_neg_c ? (XLEN'(0) - op_a) : op_a;
    b_mag_c    = b_neg_c ? (XLEN'(0) - op_b) : op_b;
    div_zero_c = (op_b == '0);
    div_ovf_c  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                 (op_a == MIN_NEG) && (op_b == '1);
    fast_c     = illegal_c || (is_div_c && (div_zero_c || div_ovf_c));
    fast_res_c = '0;
    if (illegal_c) begin
      fast_res_c = '0;
    end else if (div_zero_c) begin
      fast_res_c = funct3[1] ? op_a : '1;
    end else if (div_ovf_c) begin
      fast_res_c = funct3[1] ? '0 : op_a;
    end
  end

  // One iteration step of each algorithm plus the sign-corrected final selection.
  logic [XLEN:0]   mul_sum_c;
  logic [W2-1:0]   mul_acc_c;
  logic [XLEN:0]   div_shift_c;
  logic [XLEN:0]   div_diff_c;
  logic [W2-1:0]   div_acc_c;
  logic [W2-1:0]   prod_c;
  logic [XLEN-1:0] quo_c;
  logic [XLEN-1:0] rem_c;
  logic [XLEN-1:0] fin_res_c;
  logic            last_c;

  always_comb begin
    mul_sum_c   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_acc_c   = {mul_sum_c, acc_q[XLEN-1:1]};
    div_shift_c = acc_q[W2-1:XLEN-1];
    div_diff_c  = div_shift_c - {1'b0, mcand_q};
    div_acc_c   = {(div_diff_c[XLEN] ? div_shift_c[XLEN-1:0] : div_diff_c[XLEN-1:0]),
                   acc_q[XLEN-2:0], ~div_diff_c[XLEN]};
    prod_c      = neg_q  ? (W2'(0) - mul_acc_c) : mul_acc_c;
    quo_c       = neg_q  ? (XLEN'(0) - div_acc_c[XLEN-1:0]) : div_acc_c[XLEN-1:0];
    rem_c       = rneg_q ? (XLEN'(0) - div_acc_c[W2-1:XLEN]) : div_acc_c[W2-1:XLEN];
    last_c      = (cnt_q == CW'(XLEN - 1));
    fin_res_c   = '0;
    if (state_q == S_DIV) begin
      fin_res_c = op_q[1] ? rem_c : quo_c;
    end else begin
      fin_res_c = (op_q == F3_MUL) ? prod_c[XLEN-1:0] : prod_c[W2-1:XLEN];
    end
  end

  // State register; the visible handshake/result outputs are registered here too.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      result    <= result_d;
      error     <= error_d;
    end
  end

  // Next-state logic; flush overrides both acceptance and the result handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (fast_c)        state_d = S_DONE;
            else if (is_div_c) state_d = S_DIV;
            else               state_d = S_MUL;
          end
        end
        S_MUL, S_DIV: begin
          if (last_c) state_d = S_DONE;
        end
        S_DONE: begin
          if (out_valid && out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: out_valid rises one cycle after DONE is entered and drops on exit.
  always_comb begin
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_q == S_DONE) && (state_d == S_DONE);
    error_d     = out_valid_d && err_q;
    result_d    = out_valid_d ? res_q : result;
  end

  // Datapath: load magnitudes at accept, iterate in MUL/DIV, latch the final result.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept_c) begin
      op_q    <= funct3;
      cnt_q   <= '0;
      neg_q   <= a_neg_c ^ b_neg_c;
      rneg_q  <= a_neg_c;
      acc_q   <= is_div_c ? {XLEN'(0), a_mag_c} : {XLEN'(0), b_mag_c};
      mcand_q <= is_div_c ? b_mag_c : a_mag_c;
      res_q   <= fast_res_c;
      err_q   <= illegal_c;
    end else if ((state_q == S_MUL) || (state_q == S_DIV)) begin
      acc_q <= (state_q == S_DIV) ? div_acc_c : mul_acc_c;
      cnt_q <= cnt_q + CW'(1);
      if (last_c) res_q <= fin_res_c;
    end
  end

endmodule

// File: tb/tb_mdu_op_unit.sv
// Self-checking bench for mdu_op_unit: directed plan vectors, randomized ops
// against a 64-bit arithmetic reference, and control-path scenarios.
module tb_mdu_op_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstN, flush, in_valid, in_ready, out_valid, out_ready, error;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;

  logic        d0_flush, d0_in_valid, d0_in_ready, d0_out_valid, d0_out_ready, d0_error;
  logic [6:0]  d0_funct7;
  logic [2:0]  d0_funct3;
  logic [31:0] d0_op_a, d0_op_b, d0_result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mdu_op_unit #(.XLEN(XLEN), .HAS_DIV(1'b1)) dut (
    .clk(clk), .rstN(rstN), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .funct7(funct7), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .error(error)
  );

  mdu_op_unit #(.XLEN(XLEN), .HAS_DIV(1'b0)) dut_nodiv (
    .clk(clk), .rstN(rstN), .flush(d0_flush), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .funct7(d0_funct7), .funct3(d0_funct3), .op_a(d0_op_a), .op_b(d0_op_b),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .result(d0_result), .error(d0_error)
  );

  // Reference: RISC-V M semantics using 64-bit integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, p;
    longint      sa, sb;
    int          ia, ib;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa) * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return XLEN + 1;
    if (b == 32'h0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 40));
      1:       return 32'h0 - 32'($urandom_range(1, 40));
      2:       return MINV;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request on the main instance; out_ready is expected high.
  task automatic do_op(input logic [6:0] f7, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output logic err,
                       output int lat);
    @(negedge clk);
    funct7 = f7; funct3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    err = error;
    if (out_valid) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct7 = 7'b0000001; funct3 = 3'd0; op_a = '0; op_b = '0;
    d0_flush = 1'b0; d0_in_valid = 1'b0; d0_out_ready = 1'b1;
    d0_funct7 = 7'b0000001; d0_funct3 = 3'd0; d0_op_a = '0; d0_op_b = '0;
    #2 rstN = 1'b0;
    #10;
    n_vec++;
    if ({in_ready, out_valid, error, result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b err=%b res=%h, want 1 0 0 00000000",
               in_ready, out_valid, error, result);
    end
    n_vec++;
    if ({d0_in_ready, d0_out_valid, d0_error, d0_result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_nodiv: rdy=%b vld=%b err=%b res=%h, want 1 0 0 00000000",
               d0_in_ready, d0_out_valid, d0_error, d0_result);
    end
    @(negedge clk) rstN = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  f3s  [12] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd1};
    logic [31:0] as   [12] = '{32'd7, 32'd7, 32'd7, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100,
                               32'd5, 32'd5, MINV, MINV, MINV};
    logic [31:0] bs   [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'd3, 32'd7, 32'd7,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MINV};
    logic [31:0] exps [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h0000_0006, 32'hFFFF_FFFA,
                               32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, MINV, 32'd0,
                               32'h4000_0000};
    int          lats [12] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33};
    logic [31:0] res;
    logic        err;
    int          lat;
    for (int i = 0; i < 12; i++) begin
      do_op(7'b0000001, f3s[i], as[i], bs[i], res, err, lat);
      n_vec++;
      if (res !== exps[i] || err !== 1'b0 || lat != lats[i]) begin
        n_err++;
        $display("FAIL directed[%0d] f3=%0d: res=%h err=%b lat=%0d, want res=%h err=0 lat=%0d",
                 i, f3s[i], res, err, lat, exps[i], lats[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, res, exp_res;
    logic        err;
    int          lat, exp_lat;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      exp_res = ref_op(f3, a, b);
      exp_lat = ref_lat(f3, a, b);
      do_op(7'b0000001, f3, a, b, res, err, lat);
      n_vec++;
      if (res !== exp_res || err !== 1'b0 || lat != exp_lat) begin
        n_err++;
        $display("FAIL random[%0d] f3=%0d a=%h b=%h: res=%h err=%b lat=%0d, want res=%h err=0 lat=%0d",
                 i, f3, a, b, res, err, lat, exp_res, exp_lat);
      end
    end
  endtask

  task automatic test_illegal();
    logic [6:0]  f7s [4] = '{7'b0100000, 7'b0000000, 7'b1111111, 7'b0000011};
    logic [31:0] res;
    logic        err;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      do_op(f7s[i], 3'($urandom_range(0, 7)), $urandom, $urandom | 32'h1, res, err, lat);
      n_vec++;
      if (res !== 32'h0 || err !== 1'b1 || lat != 1) begin
        n_err++;
        $display("FAIL illegal f7=%b: res=%h err=%b lat=%0d, want res=00000000 err=1 lat=1",
                 f7s[i], res, err, lat);
      end
    end
  endtask

  task automatic test_nodiv();
    logic [2:0]  f3s  [2] = '{3'd5, 3'd0};
    logic [31:0] exps [2] = '{32'h0, 32'hFFFF_FFEB};
    logic        errs [2] = '{1'b1, 1'b0};
    int          lats [2] = '{1, 33};
    int          lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      d0_funct7 = 7'b0000001; d0_funct3 = f3s[i];
      d0_op_a = (i == 0) ? 32'd100 : 32'd7;
      d0_op_b = (i == 0) ? 32'd7 : 32'hFFFF_FFFD;
      d0_in_valid = 1'b1;
      @(posedge clk); #1;
      d0_in_valid = 1'b0;
      lat = 0;
      while (!d0_out_valid && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      n_vec++;
      if (d0_result !== exps[i] || d0_error !== errs[i] || lat != lats[i]) begin
        n_err++;
        $display("FAIL nodiv f3=%0d: res=%h err=%b lat=%0d, want res=%h err=%b lat=%0d",
                 f3s[i], d0_result, d0_error, lat, exps[i], errs[i], lats[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held, res;
    logic        err;
    int          lat;
    out_ready = 1'b0;
    @(negedge clk);
    funct7 = 7'b0000001; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    held = result;
    n_vec++;
    if (held !== 32'd14 || lat != 33) begin
      n_err++;
      $display("FAIL bp_result: res=%0d lat=%0d, want res=14 lat=33", held, lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (result !== 32'd14 || out_valid !== 1'b1 || in_ready !== 1'b0 || error !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: res=%0d vld=%b rdy=%b err=%b, want 14 1 0 0",
                 i, result, out_valid, in_ready, error);
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || error !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: vld=%b rdy=%b err=%b, want 0 1 0", out_valid, in_ready, error);
    end
    do_op(7'b0000001, 3'd7, 32'd100, 32'd7, res, err, lat);
    n_vec++;
    if (res !== 32'd2 || err !== 1'b0 || lat != 33) begin
      n_err++;
      $display("FAIL bp_next_op: res=%0d err=%b lat=%0d, want 2 0 33", res, err, lat);
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    logic        err;
    int          lat, seen;
    @(negedge clk);
    funct7 = 7'b0000001; funct3 = 3'd1; op_a = 32'd7; op_b = 32'hFFFF_FFFD; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || error !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: rdy=%b vld=%b err=%b, want 1 0 0", in_ready, out_valid, error);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL flush_no_result: out_valid cycles=%0d, want 0", seen);
    end
    // Flush beats acceptance in the same cycle.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_vs_accept: rdy=%b, want 1", in_ready);
    end
    do_op(7'b0000001, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, err, lat);
    n_vec++;
    if (res !== 32'hFFFF_FFFF || err !== 1'b0 || lat != 33) begin
      n_err++;
      $display("FAIL flush_next_op: res=%h err=%b lat=%0d, want ffffffff 0 33", res, err, lat);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    logic        err;
    int          lat;
    @(negedge clk);
    funct7 = 7'b0000001; funct3 = 3'd4; op_a = 32'hFFFF_FFEC; op_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || error !== 1'b0 || result !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: vld=%b rdy=%b err=%b res=%h, want 0 1 0 00000000",
               out_valid, in_ready, error, result);
    end
    @(negedge clk) rstN = 1'b1;
    do_op(7'b0000001, 3'd4, 32'hFFFF_FFEC, 32'd3, res, err, lat);
    n_vec++;
    if (res !== 32'hFFFF_FFFA || err !== 1'b0 || lat != 33) begin
      n_err++;
      $display("FAIL after_reset_op: res=%h err=%b lat=%0d, want fffffffa 0 33", res, err, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_nodiv();
    test_backpressure();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_op_unit.md
Name: mdu_op_unit

Overview:
- Parametrised successor to the ALU opcode decoder; decodes the RV32M/RV64M funct7/funct3 space and executes the selected multiply/divide operation iteratively.
- Sits beside the ALU in the execute stage.
- Pipeline control stalls on in_ready/out_valid.
- Illegal encodings are flagged on an error output instead of silently defaulting.

Parameters:
- XLEN, 32, operand/result width in bits (32 or 64).
- HAS_DIV, 1, 1 = DIV/DIVU/REM/REMU supported; 0 = those encodings flagged as error.

Ports:
- clk  input  1  system clock, rising edge.
- rstN  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns to IDLE, discards operation.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept (high only in IDLE).
- funct7  input  7  instruction funct7; must be 7'b0000001.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  input  XLEN  rs1 value.
- op_b  input  XLEN  rs2 value.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  XLEN  operation result.
- error  output  1  illegal encoding; valid with out_valid.

Behaviour:
- Reset (rstN low, asynchronous):
  - state=IDLE; in_ready=1; out_valid=0; result=0; error=0; internal registers cleared.
- States: IDLE, MUL, DIV, DONE.
- Accept when in_valid && in_ready at a rising edge; funct3/funct7/op_a/op_b are captured on that edge.
- Decode at accept:
  - funct7 != 0000001, or a div-class funct3 with HAS_DIV=0 -> DONE next cycle, result=0, error=1.
  - funct3 0-3 -> MUL.
    - Capture operand magnitudes and the sign of the final product.
    - Signedness: MULH both signed; MULHSU a signed, b unsigned; MULHU and MUL unsigned (MUL low half is sign-agnostic).
  - funct3 4-7, op_b==0 -> DONE next cycle, no iteration.
    - DIV/DIVU result all ones.
    - REM/REMU result = op_a.
  - DIV/REM with op_a = most negative value and op_b = all ones -> DONE next cycle.
    - DIV result = op_a.
    - REM result = 0.
  - Other div cases -> DIV.
    - Signed ops use magnitudes.
    - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
- MUL state:
  - Radix-2 shift-add over a 2*XLEN accumulator, one multiplier bit per cycle; iteration counter runs 0..XLEN-1.
  - Exactly XLEN cycles, then DONE.
  - On exit, negate the 2*XLEN product if the sign flag is set.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- DIV state:
  - Restoring division, one quotient bit per cycle, exactly XLEN cycles, then DONE.
  - On exit, apply the sign correction.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Latency: accept at edge k -> out_valid high from edge k+XLEN+1 for iterative ops, from edge k+1 for fast-path and error cases.
- DONE:
  - out_valid=1; result and error held stable until out_valid && out_ready at an edge, then -> IDLE.
  - in_ready=0 in DONE, so there is no back-to-back overlap; next accept is possible in the cycle after the handshake.
- error is 0 whenever out_valid=0.
- flush:
  - Any state -> IDLE at the next edge; out_valid drops and no result is produced.
  - flush has priority over acceptance and over the out_ready handshake in the same cycle.
- Counter wrap: the counter resets to 0 on every accept; no stale count carries across operations.
- Reset asserted mid-operation: immediate return to the reset values above.
- Width: all internal arithmetic is in 2*XLEN or XLEN+1 bits; no truncation before the final selection.

Test Plan:
- MUL: op_a=7, op_b=-3 (0xFFFFFFFD) -> after 33 cycles result=0xFFFFFFEB, error=0; MULH same operands -> 0xFFFFFFFF; MULHU same operands -> 0x00000006.
- DIV: op_a=-20, op_b=3 -> DIV 0xFFFFFFFA (-6), REM 0xFFFFFFFE (-2), both after 33 cycles; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Fast path:
  - DIV 5/0 -> 0xFFFFFFFF after 1 cycle.
  - REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and REM of the same -> 0, both after 1 cycle.
- Illegal encoding:
  - funct7=0100000 -> out_valid after 1 cycle, error=1, result=0.
  - HAS_DIV=0 build with DIVU -> error=1.
- Backpressure and flush:
  - Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready=0; release -> IDLE, new accept next cycle.
  - Assert flush in MUL cycle 5 -> IDLE next edge, no out_valid.
- Async reset: drop rstN mid-DIV between clock edges -> out_valid=0 and in_ready=1 immediately; first operation after release completes correctly.
